// File: rtl/apb_request_arbiter.sv
// Round-robin arbiter sharing one APB master command port between NUM_REQ requesters.
// Optional WAIT-state abort enabled with `define ARB_TIMEOUT_EN (limit = TIMEOUT_CYCLES).
module apb_request_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [2*NUM_REQ-1:0]      req_sel,
  input  logic [DATA_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
  input  logic [DATA_W*NUM_REQ-1:0] req_wait_cycles,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic [DATA_W-1:0]         rdata,
  output logic                      pb_start,
  output logic                      pb_write,
  output logic [1:0]                pb_sel,
  output logic [DATA_W-1:0]         pb_addr,
  output logic [DATA_W-1:0]         pb_wdata,
  output logic [DATA_W-1:0]         pb_wait_cycles,
  input  logic                      pb_ready,
  input  logic [DATA_W-1:0]         pb_rdata
);

  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q;
  logic [OWN_W-1:0]    ptr_q;
  logic [OWN_W-1:0]    owner_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [NUM_REQ-1:0]  done_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                pb_start_q;
  logic                pb_write_q;
  logic [1:0]          pb_sel_q;
  logic [DATA_W-1:0]   pb_addr_q;
  logic [DATA_W-1:0]   pb_wdata_q;
  logic [DATA_W-1:0]   pb_wait_q;

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]     to_cnt_q;
`endif

  logic                pick_vld_d;
  logic [OWN_W-1:0]    pick_idx_d;
  logic [OWN_W-1:0]    cand_d;
  logic                pick_write_d;
  logic [1:0]          pick_sel_d;
  logic [DATA_W-1:0]   pick_addr_d;
  logic [DATA_W-1:0]   pick_wdata_d;
  logic [DATA_W-1:0]   pick_wait_d;

  // Explicit wrap so non-power-of-two NUM_REQ never produces an out-of-range index.
  function automatic logic [OWN_W-1:0] wrap_inc(input logic [OWN_W-1:0] idx);
    if (idx == OWN_W'(NUM_REQ - 1)) return '0;
    return idx + 1'b1;
  endfunction

  always_comb begin
    pick_vld_d = 1'b0;
    pick_idx_d = '0;
    cand_d     = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_vld_d && req[cand_d]) begin
        pick_vld_d = 1'b1;
        pick_idx_d = cand_d;
      end
      cand_d = wrap_inc(cand_d);
    end
  end

  always_comb begin
    pick_write_d = 1'b0;
    pick_sel_d   = '0;
    pick_addr_d  = '0;
    pick_wdata_d = '0;
    pick_wait_d  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx_d == OWN_W'(i)) begin
        pick_write_d = req_write[i];
        pick_sel_d   = req_sel[2*i +: 2];
        pick_addr_d  = req_addr[DATA_W*i +: DATA_W];
        pick_wdata_d = req_wdata[DATA_W*i +: DATA_W];
        pick_wait_d  = req_wait_cycles[DATA_W*i +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      pb_start_q <= 1'b0;
      pb_write_q <= 1'b0;
      pb_sel_q   <= 2'b00;
      pb_addr_q  <= '0;
      pb_wdata_q <= '0;
      pb_wait_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= '0;
          err_q  <= 1'b0;
          if (pick_vld_d) begin
            owner_q    <= pick_idx_d;
            gnt_q      <= NUM_REQ'(1) << pick_idx_d;
            pb_write_q <= pick_write_d;
            pb_sel_q   <= pick_sel_d;
            pb_addr_q  <= pick_addr_d;
            pb_wdata_q <= pick_wdata_d;
            pb_wait_q  <= pick_wait_d;
            // Slave id 0 is unmapped: answer with an error without touching the bus.
            if (pick_sel_d == 2'b00) begin
              done_q  <= NUM_REQ'(1) << pick_idx_d;
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              pb_start_q <= 1'b1;
              state_q    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          pb_start_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
          to_cnt_q   <= '0;
`endif
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (pb_ready) begin
            if (!pb_write_q) rdata_q <= pb_rdata;
            done_q  <= gnt_q;
            err_q   <= 1'b0;
            state_q <= S_DONE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            done_q  <= gnt_q;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
        S_DONE: begin
          done_q  <= '0;
          err_q   <= 1'b0;
          gnt_q   <= '0;
          ptr_q   <= wrap_inc(owner_q);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt            = gnt_q;
  assign done           = done_q;
  assign err            = err_q;
  assign rdata          = rdata_q;
  assign pb_start       = pb_start_q;
  assign pb_write       = pb_write_q;
  assign pb_sel         = pb_sel_q;
  assign pb_addr        = pb_addr_q;
  assign pb_wdata       = pb_wdata_q;
  assign pb_wait_cycles = pb_wait_q;

endmodule

// File: tb/tb_apb_request_arbiter.sv
// Self-checking bench for apb_request_arbiter: behavioural APB master/slave memory and
// a round-robin reference model; timeout scenario built only with ARB_TIMEOUT_EN.
module tb_apb_request_arbiter;
  localparam int N = 4;
  localparam int W = 8;
`ifdef ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   req_write = '0;
  logic [2*N-1:0] req_sel = '0;
  logic [W*N-1:0] req_addr = '0;
  logic [W*N-1:0] req_wdata = '0;
  logic [W*N-1:0] req_wait_cycles = '0;
  logic [N-1:0]   gnt, done;
  logic           err, pb_start, pb_write;
  logic [W-1:0]   rdata, pb_addr, pb_wdata, pb_wait_cycles;
  logic [1:0]     pb_sel;
  logic           pb_ready;
  logic [W-1:0]   pb_rdata = '0;
  logic           m_ready = 1'b0;
  logic           spur_ready = 1'b0;

  assign pb_ready = m_ready | spur_ready;

  int tests = 0;
  int fails = 0;

  // Environment: slave memory, requester field shadows, reference arbitration state.
  logic [W-1:0] mem [4][256];
  bit           master_en = 1'b1;
  int           ref_ptr = 0;
  logic [W-1:0] ref_rdata = '0;
  logic         ready_at_edge = 1'b0;
  bit           f_wr [N];
  logic [1:0]   f_sel [N];
  logic [W-1:0] f_addr [N];
  logic [W-1:0] f_wd [N];

  // Observations from the most recent transfer.
  logic [N-1:0] o_gnt, o_done;
  int           o_starts, o_cycles;
  logic         o_err, o_write, o_rdy;
  logic [1:0]   o_sel;
  logic [W-1:0] o_addr, o_wdata, o_rdata;
  bit           o_to, o_gnt_hold;

  logic [1:0]   m_sel;
  logic [W-1:0] m_addr, m_wd;
  logic         m_wr;
  int           m_wt;

  always #5 clk = ~clk;
  always @(posedge clk) ready_at_edge <= pb_ready;

  apb_request_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_write(req_write), .req_sel(req_sel),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wait_cycles(req_wait_cycles),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata), .pb_start(pb_start),
    .pb_write(pb_write), .pb_sel(pb_sel), .pb_addr(pb_addr), .pb_wdata(pb_wdata),
    .pb_wait_cycles(pb_wait_cycles), .pb_ready(pb_ready), .pb_rdata(pb_rdata)
  );

  // APB master + slaves: accept a start, wait the requested cycles, answer once.
  initial begin
    forever begin
      @(negedge clk);
      if (master_en && pb_start && !reset) begin
        m_sel = pb_sel; m_addr = pb_addr; m_wr = pb_write; m_wd = pb_wdata;
        m_wt = int'(pb_wait_cycles);
        @(negedge clk);
        for (int k = 0; k < m_wt; k++) @(negedge clk);
        m_ready = 1'b1;
        pb_rdata = m_wr ? W'($urandom) : mem[m_sel][m_addr];
        if (m_wr) mem[m_sel][m_addr] = m_wd;
        @(negedge clk);
        m_ready = 1'b0;
        pb_rdata = W'($urandom);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    return N'(1) << i;
  endfunction

  task automatic set_req(input int i, input bit wr, input logic [1:0] sel,
                         input logic [W-1:0] a, input logic [W-1:0] d, input logic [W-1:0] wt);
    req_write[i] = wr; req_sel[2*i +: 2] = sel; req_addr[W*i +: W] = a;
    req_wdata[W*i +: W] = d; req_wait_cycles[W*i +: W] = wt; req[i] = 1'b1;
    f_wr[i] = wr; f_sel[i] = sel; f_addr[i] = a; f_wd[i] = d;
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    ref_ptr = 0; ref_rdata = '0;
  endtask

  // Observe one transfer until a done pulse; the owner then drops its request.
  task automatic run_xfer(input int budget);
    o_gnt = '0; o_done = '0; o_starts = 0; o_cycles = 0; o_to = 1'b1; o_gnt_hold = 1'b1;
    o_err = 1'b0; o_rdy = 1'b0; o_write = 1'b0; o_sel = '0; o_addr = '0; o_wdata = '0; o_rdata = '0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (o_gnt == '0) o_gnt = gnt;
      else if (gnt !== o_gnt) o_gnt_hold = 1'b0;
      if (pb_start) begin
        o_starts++; o_write = pb_write; o_sel = pb_sel; o_addr = pb_addr; o_wdata = pb_wdata;
      end
      if (done != '0) begin
        o_done = done; o_err = err; o_rdata = rdata; o_rdy = ready_at_edge;
        o_cycles = n + 1; o_to = 1'b0;
        req = req & ~done;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({gnt, done, err, pb_start, pb_write, pb_sel} !== '0) begin
      fails++; $display("FAIL reset_ctrl: got gnt=%b done=%b err=%b start=%b write=%b sel=%b, want all 0",
                        gnt, done, err, pb_start, pb_write, pb_sel);
    end
    tests++;
    if ({rdata, pb_addr, pb_wdata, pb_wait_cycles} !== '0) begin
      fails++; $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h wait=%h, want 0",
                        rdata, pb_addr, pb_wdata, pb_wait_cycles);
    end
    reset = 1'b0;
    ref_ptr = 0; ref_rdata = '0;
  endtask

  task automatic test_single_write();
    set_req(1, 1'b1, 2'b01, 8'h10, 8'hA5, 8'h00);
    run_xfer(20);
    tests++;
    if (o_to || o_gnt !== 4'b0010 || !o_gnt_hold) begin
      fails++; $display("FAIL write_gnt: got gnt=%b hold=%0d timeout=%0d, want 0010 held", o_gnt, o_gnt_hold, o_to);
    end
    tests++;
    if (o_starts !== 1 || {o_write, o_sel, o_addr, o_wdata} !== {1'b1, 2'b01, 8'h10, 8'hA5}) begin
      fails++; $display("FAIL write_pb: got starts=%0d wr=%b sel=%b addr=%h wdata=%h, want 1 1 01 10 a5",
                        o_starts, o_write, o_sel, o_addr, o_wdata);
    end
    tests++;
    if (o_done !== 4'b0010 || o_err !== 1'b0 || o_rdy !== 1'b1 || o_rdata !== ref_rdata) begin
      fails++; $display("FAIL write_done: got done=%b err=%b ready_prev=%b rdata=%h, want 0010 0 1 %h",
                        o_done, o_err, o_rdy, o_rdata, ref_rdata);
    end
    @(negedge clk);
    tests++;
    if (done !== '0 || gnt !== '0) begin
      fails++; $display("FAIL write_pulse: got done=%b gnt=%b after done, want 0 0", done, gnt);
    end
    ref_ptr = 2;
  endtask

  task automatic test_read();
    mem[2][8'h20] = 8'h3C;
    set_req(0, 1'b0, 2'b10, 8'h20, 8'h00, 8'h01);
    run_xfer(20);
    tests++;
    if (o_to || o_gnt !== 4'b0001 || o_done !== 4'b0001 || o_err !== 1'b0 || o_rdata !== 8'h3C) begin
      fails++; $display("FAIL read: got gnt=%b done=%b err=%b rdata=%h timeout=%0d, want 0001 0001 0 3c",
                        o_gnt, o_done, o_err, o_rdata, o_to);
    end
    ref_rdata = 8'h3C; ref_ptr = 1;
    @(negedge clk);
  endtask

  task automatic test_ready_outside_wait();
    bit bad = 1'b0;
    spur_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done !== '0 || gnt !== '0 || pb_start !== 1'b0 || rdata !== ref_rdata) bad = 1'b1;
    end
    spur_ready = 1'b0;
    tests++;
    if (bad) begin
      fails++; $display("FAIL idle_ready: got done=%b gnt=%b start=%b rdata=%h, want idle with rdata %h",
                        done, gnt, pb_start, rdata, ref_rdata);
    end
  endtask

  task automatic test_invalid_sel();
    set_req(2, 1'b0, 2'b00, 8'h44, 8'h55, 8'h00);
    run_xfer(10);
    tests++;
    if (o_to || o_starts !== 0 || o_done !== 4'b0100 || o_err !== 1'b1 || o_cycles !== 1 || o_rdata !== ref_rdata) begin
      fails++; $display("FAIL bad_sel: got starts=%0d done=%b err=%b cycles=%0d rdata=%h, want 0 0100 1 1 %h",
                        o_starts, o_done, o_err, o_cycles, o_rdata, ref_rdata);
    end
    ref_ptr = 3;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    bit seen = 1'b0;
    master_en = 1'b0;
    set_req(3, 1'b0, 2'b11, 8'h33, 8'h00, 8'h00);
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (pb_start) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++; $display("FAIL mid_start: got no pb_start within 10 cycles, want one");
    end
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b1;
    #1;
    tests++;
    if (gnt !== '0 || done !== '0 || pb_start !== 1'b0 || pb_addr !== '0 || rdata !== '0) begin
      fails++; $display("FAIL mid_reset: got gnt=%b done=%b start=%b addr=%h rdata=%h, want all 0",
                        gnt, done, pb_start, pb_addr, rdata);
    end
    @(negedge clk);
    reset = 1'b0; req = '0; master_en = 1'b1;
    ref_ptr = 0; ref_rdata = '0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 2'($urandom_range(1, 3)), W'($urandom_range(0, 7)), W'($urandom), 8'h00);
    run_xfer(20);
    tests++;
    if (o_to || o_gnt !== oh(rr_pick(4'b1111, ref_ptr)) || o_done !== o_gnt) begin
      fails++; $display("FAIL mid_next: got gnt=%b done=%b, want %b", o_gnt, o_done, oh(rr_pick(4'b1111, ref_ptr)));
    end
    ref_ptr = (rr_pick(4'b1111, ref_ptr) + 1) % N;
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int exp;
    pulse_reset();
    for (int i = 0; i < N; i++)
      set_req(i, 1'($urandom), 2'($urandom_range(1, 3)), W'($urandom_range(0, 7)), W'($urandom), W'($urandom_range(0, 2)));
    for (int t = 0; t < 5; t++) begin
      exp = rr_pick(req, ref_ptr);
      run_xfer(40);
      if (!f_wr[exp]) ref_rdata = mem[f_sel[exp]][f_addr[exp]];
      tests++;
      if (o_to || o_gnt !== oh(exp) || o_done !== oh(exp) || o_err !== 1'b0 || o_rdata !== ref_rdata) begin
        fails++; $display("FAIL rr_%0d: got gnt=%b done=%b err=%b rdata=%h, want %b %b 0 %h",
                          t, o_gnt, o_done, o_err, o_rdata, oh(exp), oh(exp), ref_rdata);
      end
      ref_ptr = (exp + 1) % N;
      set_req(exp, 1'($urandom), 2'($urandom_range(1, 3)), W'($urandom_range(0, 7)), W'($urandom), W'($urandom_range(0, 2)));
      @(negedge clk);
      tests++;
      if (gnt !== '0 || done !== '0) begin
        fails++; $display("FAIL rr_gap_%0d: got gnt=%b done=%b in gap, want 0 0", t, gnt, done);
      end
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int exp;
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom), 2'($urandom_range(0, 3)), W'($urandom_range(0, 7)), W'($urandom), W'($urandom_range(0, 3)));
      if (req == '0)
        set_req(t % N, 1'b0, 2'($urandom_range(0, 3)), W'($urandom_range(0, 7)), 8'h00, 8'h00);
      exp = rr_pick(req, ref_ptr);
      run_xfer(60);
      if (f_sel[exp] != 2'b00 && !f_wr[exp]) ref_rdata = mem[f_sel[exp]][f_addr[exp]];
      tests++;
      if (o_to || o_gnt !== oh(exp) || o_done !== oh(exp) || o_err !== (f_sel[exp] == 2'b00)
          || o_starts !== ((f_sel[exp] == 2'b00) ? 0 : 1) || o_rdata !== ref_rdata) begin
        fails++; $display("FAIL rand_%0d: got gnt=%b done=%b err=%b starts=%0d rdata=%h, want %b %b %b %0d %h",
                          t, o_gnt, o_done, o_err, o_starts, o_rdata, oh(exp), oh(exp),
                          (f_sel[exp] == 2'b00), (f_sel[exp] == 2'b00) ? 0 : 1, ref_rdata);
      end
      if (f_sel[exp] != 2'b00) begin
        tests++;
        if ({o_write, o_sel, o_addr} !== {f_wr[exp], f_sel[exp], f_addr[exp]} || (f_wr[exp] && o_wdata !== f_wd[exp])) begin
          fails++; $display("FAIL rand_pb_%0d: got wr=%b sel=%b addr=%h wdata=%h, want %b %b %h %h",
                            t, o_write, o_sel, o_addr, o_wdata, f_wr[exp], f_sel[exp], f_addr[exp], f_wd[exp]);
        end
      end
      ref_ptr = (exp + 1) % N;
      @(negedge clk);
    end
    req = '0;
    @(negedge clk);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    pulse_reset();
    master_en = 1'b0;
    set_req(1, 1'b0, 2'b01, 8'h05, 8'h00, 8'h00);
    set_req(2, 1'b1, 2'b10, 8'h06, 8'h77, 8'h00);
    run_xfer(40);
    tests++;
    if (o_to || o_done !== 4'b0010 || o_err !== 1'b1 || o_cycles !== TO + 2 || o_rdata !== ref_rdata) begin
      fails++; $display("FAIL timeout: got done=%b err=%b cycles=%0d rdata=%h, want 0010 1 %0d %h",
                        o_done, o_err, o_cycles, o_rdata, TO + 2, ref_rdata);
    end
    master_en = 1'b1;
    run_xfer(40);
    tests++;
    if (o_to || o_gnt !== 4'b0100 || o_done !== 4'b0100 || o_err !== 1'b0) begin
      fails++; $display("FAIL timeout_next: got gnt=%b done=%b err=%b, want 0100 0100 0", o_gnt, o_done, o_err);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 256; a++) mem[s][a] = W'($urandom);
    test_reset();
    test_single_write();
    test_read();
    test_ready_outside_wait();
    test_invalid_sel();
    test_reset_mid_wait();
    test_round_robin();
    test_random();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
